upe_serial_rx64: RTL and testbench

Serial receiver that recovers a 64-bit word from the single-wire, LSB-first, fixed-bit-period bit stream our boards drive onto an LED/GPIO pin. It is the receive end of the 64-bit serial debug link: a framed word arrives on one pin, is reassembled, and is presented together with its two's-complement negation. The negation matches `upe_negate64u`, so a transmitter sending a negated result can be checked against the original operand. It sits between an input pin and any on-chip checker or display logic, running from the same low-frequency clock as the transmitter.

---
 rtl/upe_serial_rx64.sv | 135 +++++++++++++
 tb/tb_upe_serial_rx64.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/upe_serial_rx64.sv
// upe_serial_rx64 -- receive end of the 64-bit single-wire serial debug link.
//
// Frame: one start bit (high), 64 data bits LSB first, one stop bit (low);
// the line idles low. Each bit lasts CLKS_PER_BIT clocks and is sampled
// HALF clocks into its period, measured from the detected start edge.
// A correctly framed word is presented on data_out together with its
// two's-complement negation on neg_out.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   rx_in       asynchronous serial line (idles low)
//   data_out    last correctly framed word
//   neg_out     (~data_out) + 1, modulo 2^64
//   data_valid  one-cycle pulse when data_out/neg_out update
//   frame_err   one-cycle pulse when the stop bit is high
//   busy        high whenever the receiver is not idle
module upe_serial_rx64 #(
   parameter int CLKS_PER_BIT = 1252,
   parameter int HALF         = CLKS_PER_BIT / 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_in,
   output logic [63:0] data_out,
   output logic [63:0] neg_out,
   output logic        data_valid,
   output logic        frame_err,
   output logic        busy
);

   localparam int DATA_W = 64;
   localparam int CNT_W  = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              state;
   state_t              state_nxt;
   logic                rx_meta;
   logic                rx_s;
   logic                rx_q;
   logic [CNT_W-1:0]    cnt;
   logic [5:0]          bit_cnt;
   logic [DATA_W-1:0]   shreg;
   logic                tick;
   logic                shift_en;
   logic                load_word;
   logic                flag_err;

   function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
      // Wraps modulo 2^64: 0 -> 0 and 0x8000...0 -> itself.
      return ~v + DATA_W'(1);
   endfunction

   // Synchronizer stage: two flops onto clk, plus one delayed copy for
   // rising-edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b0;
         rx_s    <= 1'b0;
         rx_q    <= 1'b0;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
         rx_q    <= rx_s;
      end
   end

   // The start bit is sampled half a period in; every later sample is a
   // full bit period after the previous one.
   assign tick = (state == START) ? (cnt == START_LAST) : (cnt == BIT_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rx_s && !rx_q)              state_nxt = START;
         START:   if (tick)                       state_nxt = rx_s ? DATA : IDLE;
         DATA:    if (tick && bit_cnt == 6'd63)   state_nxt = STOP;
         STOP:    if (tick)                       state_nxt = IDLE;
         default:                                 state_nxt = IDLE;
      endcase
   end

   // Output / strobe logic
   always_comb begin
      busy      = (state != IDLE);
      shift_en  = (state == DATA) && tick;
      load_word = (state == STOP) && tick && !rx_s;
      flag_err  = (state == STOP) && tick &&  rx_s;
   end

   // Timing counters: the cycle counter is held at zero while idle and
   // restarts at every sample point, so each state begins counting from 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         bit_cnt <= '0;
      end else begin
         cnt <= (state == IDLE || tick) ? '0 : cnt + CNT_W'(1);
         if (state == IDLE)  bit_cnt <= '0;
         else if (shift_en)  bit_cnt <= bit_cnt + 6'd1;
      end
   end

   // Data stage: LSB-first stream, so each new bit enters at the MSB and
   // bit 0 ends up at position 0 after 64 shifts.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg      <= '0;
         data_out   <= '0;
         neg_out    <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (shift_en) shreg <= {rx_s, shreg[DATA_W-1:1]};
         if (load_word) begin
            data_out <= shreg;
            neg_out  <= negate(shreg);
         end
         data_valid <= load_word;
         frame_err  <= flag_err;
      end
   end

endmodule

// File: tb/tb_upe_serial_rx64.sv
// Testbench for upe_serial_rx64 with CLKS_PER_BIT = 8.
// Drives whole frames at the pin, keeps a queue of the pulses each frame
// should produce (cycle, kind, word) and checks every pulse the DUT emits
// against it; the expected negation is plain 64-bit arithmetic 0 - word.
module tb_upe_serial_rx64;

   localparam int CPB  = 8;
   localparam int HALF = CPB / 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_in;
   logic [63:0] data_out;
   logic [63:0] neg_out;
   logic        data_valid;
   logic        frame_err;
   logic        busy;

   upe_serial_rx64 #(
      .CLKS_PER_BIT (CPB),
      .HALF         (HALF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_in      (rx_in),
      .data_out   (data_out),
      .neg_out    (neg_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          at;
      logic [63:0] word;
      bit          good;
   } exp_t;

   exp_t        expq[$];
   logic [63:0] last_good;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Pulse monitor: every data_valid / frame_err must match the oldest
   // outstanding expectation in cycle, kind and resulting outputs.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0 && (data_valid === 1'b1 || frame_err === 1'b1)) begin
         if (expq.size() == 0) begin
            check("unexpected_pulse", {data_valid, frame_err}, 64'd0);
         end else begin
            e = expq.pop_front();
            check("pulse_cycle", cyc, e.at);
            check("pulse_kind", {data_valid, frame_err}, e.good ? 64'd2 : 64'd1);
            check("busy_at_pulse", busy, 64'd0);
            if (e.good) last_good = e.word;
            check("data_out", data_out, last_good);
            check("neg_out", neg_out, 64'd0 - last_good);
         end
      end
   end

   // One pin value per clock, changed just after the active edge.
   task automatic drive(input logic v);
      @(posedge clk);
      #1;
      rx_in = v;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0);
   endtask

   // Sends the first nbits bits of a frame (66 = complete frame). With noise
   // set, data bits toggle randomly everywhere except their sample point.
   task automatic send_frame(input logic [63:0] w, input logic stop,
                             input bit noise, input int nbits);
      int   p0;
      logic bv;
      logic v;
      p0 = 0;
      for (int b = 0; b < nbits; b++) begin
         for (int o = 0; o < CPB; o++) begin
            if (b == 0)       bv = 1'b1;
            else if (b <= 64) bv = w[b-1];
            else              bv = stop;
            v = bv;
            if (noise && b >= 1 && b <= 64 && o != HALF) v = 1'($urandom_range(0, 1));
            drive(v);
            if (b == 0 && o == 0) begin
               p0 = cyc;
               // Edge seen 2 cycles after the pin rises (E = p0+2); the stop
               // sample is at E+HALF+65*CPB and the pulse follows it.
               if (nbits == 66) expq.push_back('{p0 + 2 + HALF + 65 * CPB + 1, w, !stop});
            end
            if (b == 0 && o == 1) begin
               @(negedge clk);
               check("busy_idle_before", busy, 64'd0);
            end
            if (b == 0 && o == 3) begin
               @(negedge clk);
               check("busy_rise", busy, 64'd1);
            end
         end
      end
   endtask

   initial begin
      logic [63:0] w;
      int          p0;

      reset = 1'b1;
      rx_in = 1'b0;
      last_good = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_data", data_out, 64'd0);
      check("rst_neg", neg_out, 64'd0);
      check("rst_valid", data_valid, 64'd0);
      check("rst_err", frame_err, 64'd0);
      check("rst_busy", busy, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(10);

      // Reference word
      send_frame(64'h5CD5153134D51532, 1'b0, 1'b0, 66);
      idle(20);
      check("s1_data", data_out, 64'h5CD5153134D51532);
      check("s1_neg", neg_out, 64'hA32AEACECB2AEACE);

      // Back-to-back zero and the overflow case
      send_frame(64'h0, 1'b0, 1'b0, 66);
      send_frame(64'h8000000000000000, 1'b0, 1'b0, 66);
      idle(20);
      check("s2_neg", neg_out, 64'h8000000000000000);

      // Two-cycle start glitch is rejected
      drive(1'b1);
      p0 = cyc;
      drive(1'b1);
      for (int i = 0; i < 20; i++) begin
         drive(1'b0);
         @(negedge clk);
         if (cyc == p0 + 3)        check("glitch_busy_rise", busy, 64'd1);
         if (cyc == p0 + HALF + 3) check("glitch_busy_fall", busy, 64'd0);
      end
      check("glitch_keep", data_out, last_good);

      // Stop bit high, line then held high: one frame_err, no new frame
      send_frame(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 66);
      repeat (40) drive(1'b1);
      @(negedge clk);
      check("stuck_high_busy", busy, 64'd0);
      check("ferr_keep", data_out, 64'h8000000000000000);
      idle(10);
      send_frame(64'($urandom) << 32 | 64'($urandom), 1'b0, 1'b0, 66);
      idle(10);

      // Reset during data bit 30 discards the partial word
      w = {32'($urandom), 32'($urandom)};
      send_frame(w, 1'b0, 1'b0, 31);
      repeat (3) drive(w[30]);
      @(posedge clk);
      #1;
      rx_in = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_data", data_out, 64'd0);
      check("mid_rst_neg", neg_out, 64'd0);
      check("mid_rst_busy", busy, 64'd0);
      last_good = '0;
      idle(10);
      send_frame(64'h0123456789ABCDEF, 1'b0, 1'b0, 66);
      idle(20);
      check("s5_data", data_out, 64'h0123456789ABCDEF);
      check("s5_neg", neg_out, 64'hFEDCBA9876543211);

      // Line noise away from the sample points
      send_frame(64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b1, 66);
      idle(20);
      check("s6_data", data_out, 64'hA5A5A5A5A5A5A5A5);

      // Random words, random stop bits and gaps
      for (int i = 0; i < 5; i++) begin
         w = {32'($urandom), 32'($urandom)};
         send_frame(w, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), 66);
         idle($urandom_range(3, 12));
      end

      idle(30);
      check("pending_pulses", expq.size(), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
